// File: rtl/man_tx_ctrl.sv
// man_tx_ctrl: frame sequencer for the reader-to-tag Manchester encoder.
// Serialises SOF, then per byte 8 LSB-first data bits and an optional odd
// parity bit, then EOF. Each bit is held on enc_data for one ETU.
module man_tx_ctrl #(
   parameter int unsigned ETU_CYCLES = 16,
   parameter int unsigned PARITY_EN  = 1,
   parameter int unsigned EOF_ETUS   = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   input  logic       tx_last,
   output logic       tx_ready,
   output logic       enc_enable,
   output logic       enc_data,
   output logic       busy,
   output logic       done,
   output logic       underrun
);
   localparam int unsigned CW = (ETU_CYCLES > 1) ? $clog2(ETU_CYCLES) : 1;
   localparam int unsigned EW = (EOF_ETUS > 1) ? $clog2(EOF_ETUS) : 1;
   localparam logic [CW-1:0] ETU_LAST = CW'(ETU_CYCLES - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [EW-1:0] EOF_LAST = EW'(EOF_ETUS - 1);
   localparam logic [EW-1:0] EOF_ONE  = EW'(1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SOF,
      ST_DATA,
      ST_PAR,
      ST_EOF
   } state_e;

   state_e        state_q, state_d;
   logic [CW-1:0] etu_cnt_q, etu_cnt_d;
   logic [2:0]    bit_idx_q, bit_idx_d;
   logic [7:0]    shreg_q, shreg_d;
   logic          last_q, last_d;
   logic          par_q, par_d;
   logic [EW-1:0] eof_cnt_q, eof_cnt_d;
   logic          enc_enable_q, enc_enable_d;
   logic          enc_data_q, enc_data_d;
   logic          done_q, done_d;
   logic          underrun_q, underrun_d;
   logic          bit_bnd;
   logic          byte_bnd;

   // State and datapath registers, asynchronously cleared
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         etu_cnt_q    <= '0;
         bit_idx_q    <= '0;
         shreg_q      <= '0;
         last_q       <= 1'b0;
         par_q        <= 1'b0;
         eof_cnt_q    <= '0;
         enc_enable_q <= 1'b0;
         enc_data_q   <= 1'b0;
         done_q       <= 1'b0;
         underrun_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         etu_cnt_q    <= etu_cnt_d;
         bit_idx_q    <= bit_idx_d;
         shreg_q      <= shreg_d;
         last_q       <= last_d;
         par_q        <= par_d;
         eof_cnt_q    <= eof_cnt_d;
         enc_enable_q <= enc_enable_d;
         enc_data_q   <= enc_data_d;
         done_q       <= done_d;
         underrun_q   <= underrun_d;
      end
   end

   // Bit and byte boundary decode
   always_comb begin
      bit_bnd  = (etu_cnt_q == ETU_LAST);
      byte_bnd = bit_bnd &&
                 ((state_q == ST_PAR) ||
                  ((state_q == ST_DATA) && (bit_idx_q == 3'd7) && (PARITY_EN == 0)));
   end

   // Next-state, ETU timing and byte loading
   always_comb begin
      state_d    = state_q;
      etu_cnt_d  = '0;
      bit_idx_d  = bit_idx_q;
      shreg_d    = shreg_q;
      last_d     = last_q;
      par_d      = par_q;
      eof_cnt_d  = '0;
      done_d     = 1'b0;
      underrun_d = 1'b0;
      if (state_q != ST_IDLE) begin
         etu_cnt_d = bit_bnd ? '0 : etu_cnt_q + CNT_ONE;
      end
      case (state_q)
         ST_IDLE: begin
            if (tx_valid && tx_ready) begin
               shreg_d = tx_data;
               last_d  = tx_last;
               par_d   = ~^tx_data;
               state_d = ST_SOF;
            end
         end
         ST_SOF: begin
            if (bit_bnd) begin
               bit_idx_d = '0;
               state_d   = ST_DATA;
            end
         end
         ST_DATA: begin
            if (bit_bnd) begin
               shreg_d   = shreg_q >> 1;
               bit_idx_d = bit_idx_q + 3'd1;
               if ((bit_idx_q == 3'd7) && (PARITY_EN != 0)) begin
                  state_d = ST_PAR;
               end
            end
         end
         ST_PAR: begin
            state_d = ST_PAR;
         end
         ST_EOF: begin
            eof_cnt_d = eof_cnt_q;
            if (bit_bnd) begin
               if (eof_cnt_q == EOF_LAST) begin
                  done_d  = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  eof_cnt_d = eof_cnt_q + EOF_ONE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
      // The byte boundary is shared by PAR and by DATA bit 7 (no parity), so it
      // overrides whatever the per-state branch chose above.
      if (byte_bnd) begin
         if (last_q) begin
            state_d = ST_EOF;
         end else if (tx_valid) begin
            shreg_d   = tx_data;
            last_d    = tx_last;
            par_d     = ~^tx_data;
            bit_idx_d = '0;
            state_d   = ST_DATA;
         end else begin
            underrun_d = 1'b1;
            state_d    = ST_EOF;
         end
      end
   end

   // Outputs: handshake, status and next values of the encoder drive flops
   always_comb begin
      busy         = (state_q != ST_IDLE);
      tx_ready     = ~rst & ((state_q == ST_IDLE) | (byte_bnd & ~last_q));
      enc_enable_d = (state_d != ST_IDLE);
      case (state_d)
         ST_SOF:  enc_data_d = 1'b1;
         ST_DATA: enc_data_d = shreg_d[0];
         ST_PAR:  enc_data_d = par_d;
         default: enc_data_d = 1'b0;
      endcase
      enc_enable = enc_enable_q;
      enc_data   = enc_data_q;
      done       = done_q;
      underrun   = underrun_q;
   end

endmodule

// File: tb/tb_man_tx_ctrl.sv
// tb_man_tx_ctrl: table-driven and randomized frame checks for man_tx_ctrl,
// with one DUT per parity setting sharing clock, reset and stimulus.
module tb_man_tx_ctrl;
   localparam int ETU  = 16;
   localparam int EOFN = 2;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_last;
   logic       sel;

   logic tv0, tv1;
   logic r0, r1, ee0, ee1, ed0, ed1, b0, b1, dn0, dn1, ur0, ur1;
   logic o_ready, o_enc_enable, o_enc_data, o_busy, o_done, o_underrun;

   assign tv0 = tx_valid & ~sel;
   assign tv1 = tx_valid & sel;
   assign o_ready      = sel ? r1  : r0;
   assign o_enc_enable = sel ? ee1 : ee0;
   assign o_enc_data   = sel ? ed1 : ed0;
   assign o_busy       = sel ? b1  : b0;
   assign o_done       = sel ? dn1 : dn0;
   assign o_underrun   = sel ? ur1 : ur0;

   always #5 clk = ~clk;

   man_tx_ctrl #(.ETU_CYCLES(ETU), .PARITY_EN(1), .EOF_ETUS(EOFN)) u_dut_par (
      .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tv0), .tx_last(tx_last),
      .tx_ready(r0), .enc_enable(ee0), .enc_data(ed0), .busy(b0), .done(dn0),
      .underrun(ur0)
   );

   man_tx_ctrl #(.ETU_CYCLES(ETU), .PARITY_EN(0), .EOF_ETUS(EOFN)) u_dut_nopar (
      .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tv1), .tx_last(tx_last),
      .tx_ready(r1), .enc_enable(ee1), .enc_data(ed1), .busy(b1), .done(dn1),
      .underrun(ur1)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Frame plan and measurements
   logic [7:0]  f_bytes[$];
   bit          f_under;
   bit          f_noise;
   bit          f_tail;
   int          meas_len;
   logic [63:0] meas_etu;

   function automatic int bpb();
      return sel ? 8 : 9;
   endfunction

   function automatic int frame_etus();
      return 1 + f_bytes.size() * bpb() + EOFN;
   endfunction

   // Reference: the bit carried by ETU number e of the planned frame
   function automatic logic etu_bit(input int e);
      int bp = bpb();
      int j, b;
      logic [7:0] byt;
      if (e == 0) return 1'b1;
      if (e <= f_bytes.size() * bp) begin
         j   = (e - 1) / bp;
         b   = (e - 1) % bp;
         byt = f_bytes[j];
         if (b < 8) return byt[b];
         return ($countones(byt) % 2) == 0;
      end
      return 1'b0;
   endfunction

   task automatic run_frame();
      int n   = f_bytes.size();
      int bp  = bpb();
      int len = ETU * frame_etus();
      int waitc = 0;
      int e, j, cnt;
      bit rdy_e, bnd;
      logic [5:0] exp, act;
      meas_len = 0;
      meas_etu = '0;
      @(negedge clk);
      tx_data  = f_bytes[0];
      tx_last  = (n == 1) && !f_under;
      tx_valid = 1'b1;
      while (o_ready !== 1'b1 && waitc < 20) begin
         @(negedge clk);
         waitc++;
      end
      check("idle ready", o_ready, 1);
      check("idle busy", o_busy, 0);
      for (int k = 0; k <= len; k++) begin
         @(negedge clk);
         e     = k / ETU;
         j     = e / bp;
         bnd   = (k % ETU == ETU - 1) && (e > 0) && (e % bp == 0) && (e <= n * bp);
         rdy_e = bnd && ((j < n) || f_under);
         if (k == len)
            exp = {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
         else
            exp = {1'b1, etu_bit(e), 1'b1, 1'b0,
                   logic'(f_under && (k == ETU * (1 + n * bp))), rdy_e};
         act = {o_enc_enable, o_enc_data, o_busy, o_done, o_underrun, o_ready};
         check($sformatf("cycle %0d {en,data,busy,done,ur,rdy}", k), act, exp);
         if (o_enc_enable) meas_len++;
         if ((k % ETU == ETU / 2) && (e < 64)) meas_etu[e] = o_enc_data;
         // drive inputs for this cycle
         if (rdy_e && j < n) begin
            tx_valid = 1'b1;
            tx_data  = f_bytes[j];
            tx_last  = (j == n - 1) && !f_under;
         end else if (rdy_e) begin
            tx_valid = 1'b0;
         end else if (f_tail && k >= len - 1) begin
            tx_valid = 1'b1;
            tx_data  = 8'h5A;
            tx_last  = 1'b1;
         end else if (f_noise && k < len - 1) begin
            tx_valid = 1'($urandom_range(1, 0));
            tx_data  = 8'($urandom);
            tx_last  = 1'($urandom_range(1, 0));
         end else begin
            tx_valid = 1'b0;
         end
      end
      @(negedge clk);
      if (f_tail) begin
         check("tail accepted in idle {busy,en,data,done}",
               {o_busy, o_enc_enable, o_enc_data, o_done}, 4'b1110);
         tx_valid = 1'b0;
         cnt = 0;
         while (o_done !== 1'b1 && cnt <= 400) begin
            @(negedge clk);
            cnt++;
         end
         check("tail frame length", cnt, 192);
         @(negedge clk);
      end
      check("post-frame {done,busy}", {o_done, o_busy}, 2'b00);
   endtask

   typedef struct {
      bit          sel;
      int          n;
      logic [31:0] bytes;
      bit          under;
      int          exp_len;
      bit          etu_chk;
      logic [11:0] exp_etu;
   } vec_t;

   vec_t tbl[6];

   initial begin
      tbl[0] = '{1'b0, 1, 32'h0000_00A5, 1'b0, 192, 1'b1, 12'h34B};
      tbl[1] = '{1'b0, 2, 32'h0000_FF01, 1'b0, 336, 1'b0, 12'h000};
      tbl[2] = '{1'b0, 1, 32'h0000_003C, 1'b1, 192, 1'b1, 12'h279};
      tbl[3] = '{1'b1, 2, 32'h0000_0180, 1'b0, 304, 1'b0, 12'h000};
      tbl[4] = '{1'b0, 3, 32'h005A_FF00, 1'b0, 480, 1'b0, 12'h000};
      tbl[5] = '{1'b1, 1, 32'h0000_00C3, 1'b1, 176, 1'b0, 12'h000};

      sel = 1'b0; f_under = 1'b0; f_noise = 1'b0; f_tail = 1'b0;
      tx_valid = 1'b0; tx_data = '0; tx_last = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("reset par {rdy,en,data,busy,done,ur}", {r0, ee0, ed0, b0, dn0, ur0}, 6'b0);
      check("reset nopar {rdy,en,data,busy,done,ur}", {r1, ee1, ed1, b1, dn1, ur1}, 6'b0);
      rst = 1'b0;
      @(negedge clk);
      check("idle after reset {rdy,busy}", {r0, b0}, 2'b10);

      for (int i = 0; i < 6; i++) begin
         sel = tbl[i].sel;
         f_bytes.delete();
         for (int b = 0; b < tbl[i].n; b++) f_bytes.push_back(tbl[i].bytes[8*b +: 8]);
         f_under = tbl[i].under;
         f_noise = (i % 2) == 1;
         f_tail  = 1'b0;
         run_frame();
         check($sformatf("vec %0d enable cycles", i), meas_len, tbl[i].exp_len);
         if (tbl[i].etu_chk) check($sformatf("vec %0d etu bits", i), meas_etu[11:0], tbl[i].exp_etu);
      end

      // Randomized frames against the reference model
      for (int r = 0; r < 12; r++) begin
         sel = 1'($urandom_range(1, 0));
         f_bytes.delete();
         for (int b = 0; b < int'($urandom_range(4, 1)); b++) f_bytes.push_back(8'($urandom));
         f_under = ($urandom_range(3, 0) == 0);
         f_noise = 1'b1;
         f_tail  = 1'b0;
         run_frame();
         check($sformatf("rand %0d enable cycles", r), meas_len, ETU * frame_etus());
      end

      // tx_valid on the final EOF boundary is taken one cycle later, in IDLE
      sel = 1'b0; f_bytes = {8'h81}; f_under = 1'b0; f_noise = 1'b0; f_tail = 1'b1;
      run_frame();
      f_tail = 1'b0;

      // Reset mid-frame at cycle 70
      sel = 1'b0;
      @(negedge clk);
      tx_data = 8'hA5; tx_last = 1'b1; tx_valid = 1'b1;
      check("rst-test ready", o_ready, 1);
      for (int k = 0; k <= 70; k++) begin
         @(negedge clk);
         tx_valid = 1'b0;
      end
      check("pre-reset {busy,en}", {o_busy, o_enc_enable}, 2'b11);
      #1 rst = 1'b1;
      #1 check("async reset {en,data,busy,rdy}", {o_enc_enable, o_enc_data, o_busy, o_ready}, 4'b0);
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         check("in reset {done,ur,busy}", {o_done, o_underrun, o_busy}, 3'b0);
      end
      rst = 1'b0;
      f_bytes = {8'hA5}; f_under = 1'b0; f_noise = 1'b0;
      run_frame();
      check("after reset enable cycles", meas_len, 192);
      check("after reset etu bits", meas_etu[11:0], 12'h34B);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
